// File: rtl/instr_mem_loader.sv
// Instruction memory with a pipelined fetch port toward IF and a streaming load port.
// Each word has a valid bit; unwritten or misaligned fetches return NOP_WORD with a fault code.
module instr_mem_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h0000_0013),
  localparam int                   WA         = $clog2(DEPTH),
  localparam int                   BA         = WA + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [BA-1:0]         f_addr,
  input  logic                  f_flush,
  output logic                  f_ready,
  output logic                  f_valid,
  output logic [DATA_WIDTH-1:0] f_data,
  output logic [1:0]            f_fault,
  input  logic                  ld_start,
  input  logic [WA-1:0]         ld_base,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic [WA:0]           ld_count
);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  localparam logic [WA:0] CNT_MAX = (WA+1)'(DEPTH);
  localparam bit          LAT2    = (RD_LATENCY == 2);

  state_e                  state_q, state_d;
  logic [WA-1:0]           ptr_q, ptr_d;
  logic [WA:0]             cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [DEPTH-1:0]        vbit_q, vbit_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [1:0]              s1_fault_q, s1_fault_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [1:0]              out_fault_q, out_fault_d;

  logic                    accept, beat;
  logic [WA-1:0]           rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_fault;
  logic                    take_v;
  logic [DATA_WIDTH-1:0]   take_d;
  logic [1:0]              take_f;

  // Output process of the FSM: the two ports are mutually exclusive by state.
  always_comb begin
    f_ready  = (state_q == S_IDLE);
    ld_ready = (state_q == S_LOAD);
  end

  assign accept = f_req && f_ready;
  assign beat   = ld_valid && ld_ready;
  assign rd_idx = f_addr[BA-1:2];

  // Next-state process.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ld_start) state_d = S_LOAD;
      S_LOAD:  if (beat && ld_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Loader pointer, word count and valid bits.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    vbit_d = vbit_q;
    done_d = beat && ld_last;
    if (state_q == S_IDLE && ld_start) begin
      ptr_d = ld_base;
      cnt_d = '0;
    end
    if (beat) begin
      vbit_d[ptr_q] = 1'b1;
      ptr_d         = ptr_q + 1'b1;
      cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Fetch lookup in the accept cycle; misalignment takes priority over the valid bit.
  always_comb begin
    rd_data  = NOP_WORD;
    rd_fault = 2'b01;
    if (f_addr[1:0] == 2'b00) begin
      if (vbit_q[rd_idx]) begin
        rd_data  = mem_q[rd_idx];
        rd_fault = 2'b00;
      end else begin
        rd_fault = 2'b10;
      end
    end
  end

  // Fetch pipeline: with two stages the flush kills the one result still in stage 1.
  always_comb begin
    s1_valid_d  = accept;
    s1_data_d   = accept ? rd_data  : s1_data_q;
    s1_fault_d  = accept ? rd_fault : s1_fault_q;
    take_v      = LAT2 ? (s1_valid_q && !f_flush) : accept;
    take_d      = LAT2 ? s1_data_q  : rd_data;
    take_f      = LAT2 ? s1_fault_q : rd_fault;
    out_valid_d = take_v;
    out_data_d  = take_v ? take_d : out_data_q;
    out_fault_d = take_v ? take_f : out_fault_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      vbit_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_fault_q  <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_fault_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      vbit_q      <= vbit_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_fault_q  <= s1_fault_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_fault_q <= out_fault_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; cleared valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (beat) mem_q[ptr_q] <= ld_data;
  end

  assign f_valid  = out_valid_q;
  assign f_data   = out_data_q;
  assign f_fault  = out_fault_q;
  assign ld_done  = done_q;
  assign ld_count = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: RD_LATENCY=1 and RD_LATENCY=2 instances share one stimulus
// stream and are compared every cycle against a queue-based behavioural model.
module tb_instr_mem_loader;

  localparam int DEPTH = 16;
  localparam int WA    = $clog2(DEPTH);
  localparam int BA    = WA + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] d;
    logic [1:0]  f;
  } res_t;

  logic          clk, rst;
  logic          f_req, f_flush, ld_start, ld_valid, ld_last;
  logic [BA-1:0] f_addr;
  logic [WA-1:0] ld_base;
  logic [31:0]   ld_data;

  logic          f_ready_o [2];
  logic          f_valid_o [2];
  logic [31:0]   f_data_o  [2];
  logic [1:0]    f_fault_o [2];
  logic          ld_ready_o[2];
  logic          ld_done_o [2];
  logic [WA:0]   ld_count_o[2];

  instr_mem_loader #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RD_LATENCY(1), .NOP_WORD(NOP)) u_dut_l1 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_ready(f_ready_o[0]), .f_valid(f_valid_o[0]), .f_data(f_data_o[0]), .f_fault(f_fault_o[0]),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready_o[0]), .ld_done(ld_done_o[0]), .ld_count(ld_count_o[0]));

  instr_mem_loader #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RD_LATENCY(2), .NOP_WORD(NOP)) u_dut_l2 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_ready(f_ready_o[1]), .f_valid(f_valid_o[1]), .f_data(f_data_o[1]), .f_fault(f_fault_o[1]),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready_o[1]), .ld_done(ld_done_o[1]), .ld_count(ld_count_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec, n_bad, cyc;
  logic [31:0] mem_m [DEPTH];
  bit          vb_m  [DEPTH];
  bit          loading_m, done_m;
  int          ptr_m, cnt_m;
  res_t        pq [2][$];
  logic [31:0] hold_d [2];
  logic [1:0]  hold_f [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model_read(input logic [BA-1:0] a);
    res_t r;
    r.acc = 0;
    r.due = 0;
    if (a[1:0] != 2'b00) begin
      r.d = NOP; r.f = 2'b01;
    end else if (!vb_m[int'(a[BA-1:2])]) begin
      r.d = NOP; r.f = 2'b10;
    end else begin
      r.d = mem_m[int'(a[BA-1:2])]; r.f = 2'b00;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0; f_flush = 1'b0; ld_start = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #2;
    loading_m = 1'b0; done_m = 1'b0; ptr_m = 0; cnt_m = 0;
    for (int i = 0; i < DEPTH; i++) vb_m[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pq[k].delete();
      hold_d[k] = '0;
      hold_f[k] = '0;
      check($sformatf("rst f_ready[%0d]", k),  64'(f_ready_o[k]),  64'd1);
      check($sformatf("rst f_valid[%0d]", k),  64'(f_valid_o[k]),  64'd0);
      check($sformatf("rst f_data[%0d]", k),   64'(f_data_o[k]),   64'd0);
      check($sformatf("rst f_fault[%0d]", k),  64'(f_fault_o[k]),  64'd0);
      check($sformatf("rst ld_ready[%0d]", k), 64'(ld_ready_o[k]), 64'd0);
      check($sformatf("rst ld_done[%0d]", k),  64'(ld_done_o[k]),  64'd0);
      check($sformatf("rst ld_count[%0d]", k), 64'(ld_count_o[k]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the same edge, compare both instances.
  task automatic cycle(input logic req, input logic [BA-1:0] addr, input logic flush,
                       input logic start, input logic [WA-1:0] base, input logic vld,
                       input logic [31:0] data, input logic last);
    res_t r;
    logic exp_v;
    f_req = req; f_addr = addr; f_flush = flush; ld_start = start; ld_base = base;
    ld_valid = vld; ld_data = data; ld_last = last;
    @(posedge clk);
    #1;
    cyc++;
    if (flush) begin
      pq[0].delete();
      pq[1].delete();
    end
    if (req && !loading_m) begin
      r = model_read(addr);
      r.acc = cyc;
      for (int k = 0; k < 2; k++) begin
        r.due = cyc + k;
        pq[k].push_back(r);
      end
    end
    done_m = 1'b0;
    if (loading_m) begin
      if (vld) begin
        mem_m[ptr_m] = data;
        vb_m[ptr_m]  = 1'b1;
        ptr_m        = (ptr_m + 1) % DEPTH;
        if (cnt_m < DEPTH) cnt_m++;
        if (last) begin
          loading_m = 1'b0;
          done_m    = 1'b1;
        end
      end
    end else if (start) begin
      loading_m = 1'b1;
      ptr_m     = int'(base);
      cnt_m     = 0;
    end
    for (int k = 0; k < 2; k++) begin
      exp_v = 1'b0;
      if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
        exp_v     = 1'b1;
        hold_d[k] = pq[k][0].d;
        hold_f[k] = pq[k][0].f;
        void'(pq[k].pop_front());
      end
      check($sformatf("c%0d f_ready[%0d]", cyc, k),  64'(f_ready_o[k]),  64'(!loading_m));
      check($sformatf("c%0d ld_ready[%0d]", cyc, k), 64'(ld_ready_o[k]), 64'(loading_m));
      check($sformatf("c%0d ld_done[%0d]", cyc, k),  64'(ld_done_o[k]),  64'(done_m));
      check($sformatf("c%0d ld_count[%0d]", cyc, k), 64'(ld_count_o[k]), 64'(cnt_m));
      check($sformatf("c%0d f_valid[%0d]", cyc, k),  64'(f_valid_o[k]),  64'(exp_v));
      check($sformatf("c%0d f_data[%0d]", cyc, k),   64'(f_data_o[k]),   64'(hold_d[k]));
      check($sformatf("c%0d f_fault[%0d]", cyc, k),  64'(f_fault_o[k]),  64'(hold_f[k]));
    end
  endtask

  task automatic fetch(input logic [BA-1:0] a);
    cycle(1'b1, a, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask
  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask
  task automatic ld_begin(input logic [WA-1:0] b);
    cycle(1'b0, '0, 1'b0, 1'b1, b, 1'b0, '0, 1'b0);
  endtask
  task automatic ld_beat(input logic [31:0] d, input logic l);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, d, l);
  endtask

  initial begin
    logic [BA-1:0] ra;
    n_vec = 0; n_bad = 0; cyc = 0;
    rst = 1'b1;
    do_reset();

    // Unwritten word after reset.
    fetch(BA'(8'h10)); idle(); idle();

    // Four-word session at base 2, then consecutive fetches of the loaded words.
    ld_begin(WA'(2));
    for (int i = 0; i < 4; i++) ld_beat(32'hA0 + 32'(i), i == 3);
    idle();
    for (int i = 0; i < 4; i++) fetch(BA'(8'h08 + 4 * i));
    idle(); idle();

    // Misaligned fetch of a written word.
    fetch(BA'(8'h0A)); idle(); idle();

    // Wrapping session: words DEPTH-1 and 0.
    ld_begin(WA'(DEPTH - 1));
    ld_beat(32'hB0, 1'b0);
    ld_beat(32'hB1, 1'b1);
    fetch(BA'((DEPTH - 1) * 4)); fetch(BA'(0)); idle(); idle();

    // Flush on the cycle after an accept, with a new accept in the flush cycle.
    fetch(BA'(8'h08));
    cycle(1'b1, BA'(8'h0C), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    fetch(BA'(8'h10));
    idle(); idle();

    // Fetch and ld_start together: the fetch sees the old word, the load proceeds.
    ld_begin(WA'(6)); ld_beat(32'h11, 1'b1);
    cycle(1'b1, BA'(8'h18), 1'b0, 1'b1, WA'(6), 1'b0, '0, 1'b0);
    fetch(BA'(8'h18));
    ld_beat(32'h22, 1'b1);
    fetch(BA'(8'h18)); idle(); idle();

    // Saturating count: 17 beats into a 16-word memory.
    ld_begin(WA'(0));
    for (int i = 0; i < DEPTH + 1; i++) ld_beat(32'hC00 + 32'(i), i == DEPTH);
    idle();
    for (int i = 0; i < 3; i++) fetch(BA'(4 * i));
    idle(); idle();

    // Reset in the middle of a session leaves nothing readable.
    ld_begin(WA'(8));
    ld_beat(32'hD0, 1'b0);
    ld_beat(32'hD1, 1'b0);
    do_reset();
    idle();
    fetch(BA'(8'h20)); fetch(BA'(8'h24)); idle(); idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      ra = BA'($urandom);
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      cycle(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0), WA'($urandom), ($urandom_range(0, 2) != 0),
            $urandom, ($urandom_range(0, 4) == 0));
    end
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised instruction memory for the RISC-V core, with a pipelined fetch port toward the PC/IF stage and a separate streaming load port for boot/program download. Each word carries a valid bit. Fetches of never-written or misaligned addresses return a NOP and a fault code instead of stale data. It sits between the IF stage and the program loader, replacing the single-port, fixed-depth instruction memory.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- DEPTH, 256, number of words; power of two, ≥4.
- RD_LATENCY, 1, fetch latency in cycles; legal values 1 or 2.
- NOP_WORD, 32'h0000_0013, word returned on any faulted fetch (ADDI x0,x0,0).
- Derived: WA = $clog2(DEPTH) (word address bits); BA = WA+2 (byte address bits).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request.
- f_addr  in  BA  byte address of the instruction.
- f_flush  in  1  drop all fetches in flight (branch redirect).
- f_ready  out  1  fetch port can accept a request.
- f_valid  out  1  one-cycle strobe: f_data/f_fault are valid.
- f_data  out  DATA_WIDTH  fetched instruction.
- f_fault  out  2  00 ok, 01 misaligned, 10 unwritten word.
- ld_start  in  1  begin a load session.
- ld_base  in  WA  first word index of the session.
- ld_valid  in  1  load data valid.
- ld_data  in  DATA_WIDTH  word to write.
- ld_last  in  1  marks the final word of the session.
- ld_ready  out  1  loader accepts a word.
- ld_done  out  1  one-cycle pulse after the last word is written.
- ld_count  out  WA+1  words written in the current/last session.

## Operation
- FSM states IDLE and LOAD; reset state is IDLE.
- IDLE: f_ready=1, ld_ready=0. ld_start moves the FSM to LOAD next cycle; ptr<=ld_base and ld_count<=0.
- LOAD: f_ready=0, ld_ready=1. ld_start is ignored.
- Load beat (ld_valid&&ld_ready): mem[ptr]<=ld_data, vbit[ptr]<=1, ptr<=ptr+1 wrapping DEPTH-1→0, ld_count<=ld_count+1 saturating at DEPTH.
- Beat with ld_last=1: after the write, go to IDLE; ld_done=1 the following cycle.
- Fetch accept = f_req&&f_ready. The read occurs in the accept cycle. One accept per cycle; no backpressure on results.
- Result rules, misaligned first:
  - f_addr[1:0]≠0: f_data=NOP_WORD, f_fault=01.
  - Else vbit[f_addr[BA-1:2]]=0: f_data=NOP_WORD, f_fault=10.
  - Else f_data=mem word, f_fault=00.
- f_ready and ld_start both high in the same cycle: the fetch is accepted and completes normally with pre-load contents, and the FSM still enters LOAD.
- f_flush: clears every in-flight result, so no f_valid is produced for them. A request accepted in the same cycle as f_flush is kept.
- f_data/f_fault hold their last value while f_valid=0.
- Reset clears all vbits, the FSM, ptr, the fetch pipeline and all registered outputs. Memory array contents are not cleared; they become unreadable because the vbits are clear.

## Timing
- Reset values: f_ready=1, f_valid=0, f_data=0, f_fault=00, ld_ready=0, ld_done=0, ld_count=0.
- Reset mid-load or mid-fetch: the partial session is abandoned, no ld_done pulse, pending f_valid dropped.
- Fetch accepted at cycle N: f_valid=1 at N+RD_LATENCY. Back-to-back accepts give back-to-back f_valid.
- Load write at cycle N is visible to a fetch accepted at N+1 or later. Fetch is blocked in LOAD, so the first visible fetch occurs at or after the IDLE return.
- ld_start at N: ld_ready=1 from N+1.
- ld_last beat at M: ld_ready=0 and f_ready=1 from M+1; ld_done=1 at M+1 only.
- ld_count updates the cycle after each beat and holds after ld_done until the next ld_start.

## Test plan
- Reset, then fetch byte address 0x10 → f_valid at RD_LATENCY, f_data=0x00000013, f_fault=10.
- Load 4 words 0xA0..0xA3 from base 2, ld_last on the 4th → ld_done one cycle, ld_count=4; fetches of 0x08..0x14 return 0xA0..0xA3 with fault 00 on consecutive cycles.
- Fetch 0x0A → NOP_WORD, fault 01, even if word 2 is written. Load with base DEPTH-1 and 2 words → words DEPTH-1 and 0 written (wrap).
- Stream of 3 fetches, f_flush on the cycle after the first accept (RD_LATENCY=2), new accept in the flush cycle → only the new request produces f_valid.
- Same cycle f_req+ld_start with old word 0x11 at target, new load writes 0x22 → fetch returns 0x11; f_ready=0 during LOAD.
- Assert rst mid-load after 2 of 5 words → no ld_done, all outputs at reset values, subsequent fetch of loaded words gives fault 10.
